// File: rtl/vector_exec_unit.sv
// Multi-cycle lane-parallel vector execution unit: LANES elements per EXEC beat, tail elements zeroed.
// Optional macro VEC_REDSUM_EN turns mode 2'b11 into a wrapping sum reduction; otherwise mode 2'b11 is illegal.
module vector_exec_unit #(
  parameter int VECTOR_LENGTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LANES         = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_a,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_b,
  input  logic [DATA_WIDTH-1:0]               scalar,
  input  logic [4:0]                          imm5,
  input  logic [1:0]                          mode,
  input  logic [2:0]                          funct3,
  input  logic [$clog2(VECTOR_LENGTH+1)-1:0]  vl,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [VECTOR_LENGTH*DATA_WIDTH-1:0] result,
  output logic                                illegal
);
  localparam int VLW = $clog2(VECTOR_LENGTH + 1);
  localparam int IXW = $clog2(VECTOR_LENGTH);
  localparam int DW  = DATA_WIDTH;

  localparam logic [1:0] MODE_VV  = 2'b00;
  localparam logic [1:0] MODE_VX  = 2'b01;
  localparam logic [1:0] MODE_VI  = 2'b10;
  localparam logic [1:0] MODE_RED = 2'b11;

`ifdef VEC_REDSUM_EN
  localparam bit RED_EN = 1'b1;
`else
  localparam bit RED_EN = 1'b0;
`endif

  generate
    if (VECTOR_LENGTH % LANES != 0) begin : g_lanes_check
      $error("LANES must divide VECTOR_LENGTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            state_q, state_n;
  logic [DW-1:0]     a_q      [VECTOR_LENGTH];
  logic [DW-1:0]     b_q      [VECTOR_LENGTH];
  logic [DW-1:0]     result_q [VECTOR_LENGTH];
  logic [VLW-1:0]    idx_q, vl_eff_q, vl_clamp;
  logic [VLW:0]      idx_next;
  logic [1:0]        mode_q;
  logic [2:0]        funct3_q;
  logic              illegal_q, last_beat, red_mode;
  logic [DW-1:0]     acc_q, acc_next;
  logic [DW-1:0]     beat_val [LANES];
  logic              beat_en  [LANES];
  logic [IXW-1:0]    lane_idx [LANES];

  function automatic logic [DW-1:0] alu(input logic [2:0] f, input logic [DW-1:0] x,
                                        input logic [DW-1:0] y);
    case (f)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x * y;
      3'b011:  return x & y;
      3'b100:  return x | y;
      3'b101:  return x ^ y;
      3'b110:  return ($signed(x) < $signed(y)) ? x : y;
      default: return ($signed(x) > $signed(y)) ? x : y;
    endcase
  endfunction

  assign vl_clamp  = (vl > VLW'(VECTOR_LENGTH)) ? VLW'(VECTOR_LENGTH) : vl;
  assign idx_next  = {1'b0, idx_q} + (VLW+1)'(LANES);
  assign last_beat = idx_next >= {1'b0, vl_eff_q};
  assign red_mode  = RED_EN && (mode_q == MODE_RED);

  // Beat datapath; lanes past vl_eff are disabled so they leave the zeroed tail alone.
  always_comb begin
    acc_next = acc_q;
    for (int l = 0; l < LANES; l++) begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      beat_val[l] = '0;
      beat_en[l]  = 1'b0;
      lane_idx[l] = IXW'(int'(idx_q) + l);
      if (int'(idx_q) + l < int'(vl_eff_q)) begin
        beat_en[l]  = 1'b1;
        beat_val[l] = alu(funct3_q, a_q[lane_idx[l]], b_q[lane_idx[l]]);
        acc_next    = acc_next + a_q[lane_idx[l]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (vl_clamp == '0 || (mode == MODE_RED && !RED_EN)) state_n = DONE;
        else                                                  state_n = EXEC;
      end
      EXEC:    if (last_beat) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand and result arrays are plain flops and are cleared explicitly, unlike a RAM.
      for (int i = 0; i < VECTOR_LENGTH; i++) begin
        a_q[i]      <= '0;
        b_q[i]      <= '0;
        result_q[i] <= '0;
      end
      idx_q     <= '0;
      vl_eff_q  <= '0;
      mode_q    <= MODE_VV;
      funct3_q  <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          // Operand B is resolved per element at accept so EXEC never looks at mode again.
          for (int i = 0; i < VECTOR_LENGTH; i++) begin
            a_q[i]      <= vector_a[i*DW +: DW];
            result_q[i] <= '0;
            case (mode)
              MODE_VV: b_q[i] <= vector_b[i*DW +: DW];
              MODE_VX: b_q[i] <= scalar;
              MODE_VI: b_q[i] <= {{(DW-5){imm5[4]}}, imm5};
              default: b_q[i] <= '0;
            endcase
          end
          idx_q     <= '0;
          vl_eff_q  <= vl_clamp;
          mode_q    <= mode;
          funct3_q  <= funct3;
          illegal_q <= (mode == MODE_RED) && !RED_EN;
          acc_q     <= '0;
        end
        EXEC: begin
          idx_q <= idx_next[VLW-1:0];
          acc_q <= acc_next;
          if (red_mode) begin
            if (last_beat) result_q[0] <= acc_next;
          end else begin
            for (int l = 0; l < LANES; l++)
              if (beat_en[l]) result_q[lane_idx[l]] <= beat_val[l];
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < VECTOR_LENGTH; g++) begin : g_pack
      assign result[g*DW +: DW] = result_q[g];
    end
  endgenerate

  assign illegal = illegal_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Scoreboard bench for vector_exec_unit: expectations queued at issue, compared when out_valid rises.
module tb_vector_exec_unit;
  localparam int VL = 8;
  localparam int DW = 32;
  localparam int VW = VL * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] vector_a = '0;
  logic [VW-1:0] vector_b = '0;
  logic [DW-1:0] scalar = '0;
  logic [4:0]    imm5 = '0;
  logic [1:0]    mode = '0;
  logic [2:0]    funct3 = '0;
  logic [3:0]    vl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] result;
  logic          illegal;

  vector_exec_unit #(.VECTOR_LENGTH(VL), .DATA_WIDTH(DW), .LANES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .vector_a(vector_a), .vector_b(vector_b), .scalar(scalar), .imm5(imm5),
    .mode(mode), .funct3(funct3), .vl(vl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    logic          ill;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] a_arr [VL];
  logic [DW-1:0] b_arr [VL];

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input logic [2:0] f, input logic [DW-1:0] x,
                                           input logic [DW-1:0] y);
    logic signed [DW-1:0] sx, sy;
    sx = x;
    sy = y;
    case (f)
      3'd0: ref_op = x + y;
      3'd1: ref_op = x - y;
      3'd2: ref_op = x * y;
      3'd3: ref_op = x & y;
      3'd4: ref_op = x | y;
      3'd5: ref_op = x ^ y;
      3'd6: ref_op = (sx <= sy) ? x : y;
      default: ref_op = (sx >= sy) ? x : y;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] md, input logic [2:0] f,
                        input logic [3:0] vlv, input int stall, input bit pulse);
    exp_t          e;
    int            ve, lat, wait_cnt;
    logic [DW-1:0] bo;
    logic [VW-1:0] got;
    ve    = (vlv > 4'd8) ? 8 : int'(vlv);
    e.vec = '0;
    e.ill = 1'b0;
    e.lat = (ve == 0) ? 1 : (ve + 1) / 2 + 1;
    if (md == 2'b11) begin
`ifdef VEC_REDSUM_EN
      bo = '0;
      for (int i = 0; i < ve; i++) bo = bo + a_arr[i];
      e.vec[DW-1:0] = bo;
`else
      e.ill = 1'b1;
      e.lat = 1;
`endif
    end else begin
      for (int i = 0; i < ve; i++) begin
        bo = (md == 2'b00) ? b_arr[i] : (md == 2'b01) ? scalar : {{27{imm5[4]}}, imm5};
        e.vec[i*DW +: DW] = ref_op(f, a_arr[i], bo);
      end
    end
    sb.push_back(e);

    wait_cnt = 0;
    while (!in_ready && wait_cnt < 60) begin
      @(posedge clk); #1; wait_cnt++;
    end
    check({tag, ".in_ready"}, in_ready, 1'b1);
    for (int i = 0; i < VL; i++) begin
      vector_a[i*DW +: DW] = a_arr[i];
      vector_b[i*DW +: DW] = b_arr[i];
    end
    mode = md; funct3 = f; vl = vlv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      if (pulse) begin
        in_valid = ~in_valid;
        vector_a = ~vector_a;
        mode     = ~mode;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;

    e = sb.pop_front();
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".result"}, result, e.vec);
    check({tag, ".illegal"}, illegal, e.ill);
    got = result;
    repeat (stall) begin
      @(posedge clk); #1;
      check({tag, ".stall_valid"}, out_valid, 1'b1);
      check({tag, ".stall_result"}, result, got);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, out_valid, 1'b0);
    check({tag, ".ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #12;
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.result", result, '0);
    check("reset.illegal", illegal, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of EXEC drops the instruction.
    for (int i = 0; i < VL; i++) begin a_arr[i] = 32'(i + 1); b_arr[i] = 32'(7 * i); end
    for (int i = 0; i < VL; i++) begin
      vector_a[i*DW +: DW] = a_arr[i];
      vector_b[i*DW +: DW] = b_arr[i];
    end
    mode = 2'b00; funct3 = 3'd0; vl = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    check("midreset.out_valid", out_valid, 1'b0);
    check("midreset.result", result, '0);
    check("midreset.in_ready", in_ready, 1'b1);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < VL; i++) begin a_arr[i] = 32'(i); b_arr[i] = 32'(10 * i); end
    run_op("vv_add", 2'b00, 3'd0, 4'd8, 3, 1'b0);
    run_op("vl15_clamp", 2'b00, 3'd0, 4'd15, 0, 1'b0);
    run_op("vl0", 2'b00, 3'd0, 4'd0, 0, 1'b0);

    for (int i = 0; i < VL; i++) a_arr[i] = 32'd100;
    imm5 = 5'b11111;
    run_op("vi_sub_tail", 2'b10, 3'd1, 4'd3, 0, 1'b0);

    for (int i = 0; i < VL; i++) a_arr[i] = 32'h8000_0001;
    scalar = 32'd2;
    run_op("vx_mul", 2'b01, 3'd2, 4'd8, 0, 1'b0);

    for (int i = 0; i < VL; i++) begin a_arr[i] = 32'hFFFF_FFFF; b_arr[i] = 32'd1; end
    run_op("vv_min", 2'b00, 3'd6, 4'd8, 0, 1'b1);
    run_op("vv_max", 2'b00, 3'd7, 4'd8, 0, 1'b1);

    for (int i = 0; i < VL; i++) a_arr[i] = 32'(i + 1);
    run_op("mode11", 2'b11, 3'd5, 4'd4, 1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < VL; i++) begin a_arr[i] = $urandom; b_arr[i] = $urandom; end
      scalar = $urandom;
      imm5   = 5'($urandom);
      run_op("rand", 2'($urandom_range(0, 2)), 3'(t), 4'($urandom_range(0, 15)), 1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
